// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Initiator side of the accumulator-ALU command interface. A small program
// memory holds (opcode, A operand, expected result) entries. On start the
// sequencer clears the ALU register, then for each step presents the operands
// for SETTLE cycles, strobes one load, and compares the registered ALU result
// against the entry's expected value. Mismatches are counted and the first
// failing step index is recorded.
//
// Ports
//   clock, reset     single clock, synchronous active-high reset
//   prog_we/addr/op/a/exp   program memory write port (IDLE only)
//   run_len, start   steps to execute (0..DEPTH) and one-cycle start pulse
//   busy, done       run in progress / one-cycle end-of-run pulse
//   err_count, first_err_idx, first_err_seen   result of the last run
//   alu_op, alu_a, alu_load, alu_keep          command outputs to the ALU
//   alu_result       registered ALU value, valid the cycle after a load
// ----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_op,
    input  logic [3:0]    prog_a,
    input  logic [7:0]    prog_exp,
    input  logic [AW:0]   run_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_err_idx,
    output logic          first_err_seen,
    output logic [2:0]    alu_op,
    output logic [3:0]    alu_a,
    output logic          alu_load,
    output logic          alu_keep,
    input  logic [7:0]    alu_result
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SETUP = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Program memory (not reset)
    logic [2:0] mem_op_r  [DEPTH];
    logic [3:0] mem_a_r   [DEPTH];
    logic [7:0] mem_exp_r [DEPTH];

    state_t        state_r, state_s;
    logic [AW-1:0] idx_r, idx_s;
    logic [SW-1:0] settle_r, settle_s;
    logic [AW:0]   len_r, len_s;

    logic [AW:0]   err_count_s;
    logic [AW-1:0] first_err_idx_s;
    logic          first_err_seen_s;
    logic          busy_s, done_s, alu_load_s, alu_keep_s;
    logic [2:0]    alu_op_s;
    logic [3:0]    alu_a_s;
    logic          mem_we_s;
    logic          mismatch_s;
    logic          last_step_s;

    // Writes are only accepted while idle; a write in the start cycle lands
    // before the first entry is read in SETUP.
    assign mem_we_s    = prog_we && (state_r == ST_IDLE) && !reset;
    assign mismatch_s  = (alu_result != mem_exp_r[idx_r]);
    assign last_step_s = ({1'b0, idx_r} == (len_r - (AW+1)'(1)));

    // Program memory write port
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_op_r[prog_addr]  <= prog_op;
            mem_a_r[prog_addr]   <= prog_a;
            mem_exp_r[prog_addr] <= prog_exp;
        end
    end

    // Next-state, step bookkeeping and result accumulation
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        settle_s         = settle_r;
        len_s            = len_r;
        err_count_s      = err_count;
        first_err_idx_s  = first_err_idx;
        first_err_seen_s = first_err_seen;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_count_s      = '0;
                    first_err_idx_s  = '0;
                    first_err_seen_s = 1'b0;
                    idx_s            = '0;
                    if (run_len == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        len_s   = run_len;
                        state_s = ST_CLEAR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                idx_s    = '0;
                settle_s = '0;
                state_s  = ST_SETUP;
            end
            ST_SETUP: begin
                if (settle_r == SETTLE_LAST) begin
                    settle_s = '0;
                    state_s  = ST_LOAD;
                end else begin
                    settle_s = settle_r + SW'(1);
                end
            end
            ST_LOAD: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_count_s = err_count + (AW+1)'(1);
                    if (!first_err_seen) begin
                        first_err_idx_s  = idx_r;
                        first_err_seen_s = 1'b1;
                    end else begin
                        first_err_idx_s  = first_err_idx;
                        first_err_seen_s = first_err_seen;
                    end
                end else begin
                    err_count_s = err_count;
                end
                if (last_step_s) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s    = idx_r + AW'(1);
                    settle_s = '0;
                    state_s  = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_DONE);
        alu_load_s = (state_s == ST_CLEAR) || (state_s == ST_LOAD);
        alu_keep_s = (state_s != ST_CLEAR);
        alu_op_s   = 3'b111;
        alu_a_s    = 4'd0;
        case (state_s)
            ST_SETUP: begin
                alu_op_s = mem_op_r[idx_s];
                alu_a_s  = mem_a_r[idx_s];
            end
            ST_LOAD, ST_CHECK: begin
                alu_op_s = alu_op;
                alu_a_s  = alu_a;
            end
            default: begin
                alu_op_s = 3'b111;
                alu_a_s  = 4'd0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            idx_r          <= '0;
            settle_r       <= '0;
            len_r          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_seen <= 1'b0;
            alu_op         <= 3'b111;
            alu_a          <= 4'd0;
            alu_load       <= 1'b0;
            alu_keep       <= 1'b1;
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            settle_r       <= settle_s;
            len_r          <= len_s;
            busy           <= busy_s;
            done           <= done_s;
            err_count      <= err_count_s;
            first_err_idx  <= first_err_idx_s;
            first_err_seen <= first_err_seen_s;
            alu_op         <= alu_op_s;
            alu_a          <= alu_a_s;
            alu_load       <= alu_load_s;
            alu_keep       <= alu_keep_s;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_op;
    logic [3:0]    prog_a;
    logic [7:0]    prog_exp;
    logic [AW:0]   run_len;
    logic          start;
    logic          busy, done;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_idx;
    logic          first_err_seen;
    logic [2:0]    alu_op;
    logic [3:0]    alu_a;
    logic          alu_load, alu_keep;
    logic [7:0]    alu_result = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE(2)) dut (
        .clock(clock), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op),
        .prog_a(prog_a), .prog_exp(prog_exp),
        .run_len(run_len), .start(start),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_seen(first_err_seen),
        .alu_op(alu_op), .alu_a(alu_a), .alu_load(alu_load), .alu_keep(alu_keep),
        .alu_result(alu_result)
    );

    always #5 clock = ~clock;

    // ALU behaviour: 000 = A, 001 = A+B, 110 = A*B, 111 = hold, others = R^A
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [7:0] r);
        case (op)
            3'b000:  return {4'd0, a};
            3'b001:  return {4'd0, a} + {4'd0, r[3:0]};
            3'b110:  return {4'd0, a} * {4'd0, r[3:0]};
            3'b111:  return r;
            default: return r ^ {4'd0, a};
        endcase
    endfunction

    // Accumulator-ALU register driven by the sequencer
    always_ff @(posedge clock) begin
        if (alu_load) alu_result <= alu_keep ? alu_f(alu_op, alu_a, alu_result) : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic write_entry(input int addr, input int op, input int a, input int e);
        prog_we = 1'b1; prog_addr = AW'(addr); prog_op = 3'(op); prog_a = 4'(a); prog_exp = 8'(e);
        @(posedge clock); @(negedge clock);
        prog_we = 1'b0;
    endtask

    task automatic load_base();
        write_entry(0, 1, 3, 8'h03);
        write_entry(1, 1, 5, 8'h08);
        write_entry(2, 6, 2, 8'h10);
    endtask

    // Start a run from a negedge; any prog_we already set by the caller
    // coincides with the start cycle. inj != 0 pulses start and a write to
    // entry 0 in that cycle of the run.
    task automatic run_check(input string tag, input int len, input int inj,
                             input int e_err, input int e_idx, input int e_seen, input int e_lat);
        int cyc;
        int loads;
        run_len = (AW+1)'(len);
        start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = 1'b0; prog_we = 1'b0;
        run_len = (AW+1)'((len + 7) % 17);
        cyc = 1; loads = 0;
        check({tag, " busy_c1"}, busy, 1);
        if (len > 0) begin
            check({tag, " clear_load"}, alu_load, 1);
            check({tag, " clear_keep"}, alu_keep, 0);
        end
        while (1) begin
            if (inj != 0 && cyc == inj) begin
                prog_we = 1'b1; prog_addr = '0; prog_op = 3'b001; prog_a = 4'd9;
                prog_exp = 8'hAA; start = 1'b1;
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
            loads += int'(alu_load);
            if (done === 1'b1 || cyc >= 200) break;
            @(negedge clock);
            cyc++;
        end
        check({tag, " done_latency"}, cyc, e_lat);
        check({tag, " loads"}, loads, (len == 0) ? 0 : len + 1);
        check({tag, " err_count"}, err_count, e_err);
        check({tag, " first_err_idx"}, first_err_idx, e_idx);
        check({tag, " first_err_seen"}, first_err_seen, e_seen);
        check({tag, " done_op"}, {alu_op, alu_a}, {3'b111, 4'd0});
        @(negedge clock);
        prog_we = 1'b0; start = 1'b0;
        check({tag, " busy_after"}, busy, 0);
        check({tag, " done_after"}, done, 0);
        check({tag, " err_held"}, err_count, e_err);
    endtask

    typedef struct {
        int reload; int mod; int wstart;
        int maddr; int mop; int ma; int mexp;
        int len; int inj;
        int e_err; int e_idx; int e_seen; int e_lat;
    } vec_t;

    vec_t tbl[12];

    logic [2:0] mop [DEPTH];
    logic [3:0] ma  [DEPTH];
    logic [7:0] mexp[DEPTH];

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_a = '0;
        prog_exp = '0; run_len = '0; start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err_count", err_count, 0);
        check("rst first_err_idx", first_err_idx, 0);
        check("rst first_err_seen", first_err_seen, 0);
        check("rst alu_op", alu_op, 3'b111);
        check("rst alu_a", alu_a, 0);
        check("rst alu_load", alu_load, 0);
        check("rst alu_keep", alu_keep, 1);
        reset = 1'b0;
        @(negedge clock);

        //           rl mod ws ad op a  exp    len inj err idx seen lat
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,     3, 0,  0, 0, 0, 14};
        tbl[1]  = '{1, 1, 0, 1, 1, 5, 8'h09, 3, 0,  1, 1, 1, 14};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 2, 6, 2, 8'h11, 3, 0,  1, 2, 1, 14};
        tbl[4]  = '{1, 1, 0, 0, 1, 4, 8'h03, 3, 0,  3, 0, 1, 14};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0,     1, 0,  0, 0, 0, 6};
        tbl[6]  = '{1, 1, 0, 1, 1, 5, 8'hFF, 2, 0,  1, 1, 1, 10};
        tbl[7]  = '{1, 1, 1, 1, 1, 5, 8'h09, 3, 0,  1, 1, 1, 14};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0,     3, 5,  0, 0, 0, 14};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,     3, 0,  0, 0, 0, 14};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 0,     3, 14, 0, 0, 0, 14};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0,     3, 0,  0, 0, 0, 14};

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].reload != 0) load_base();
            if (tbl[i].mod != 0 && tbl[i].wstart == 0)
                write_entry(tbl[i].maddr, tbl[i].mop, tbl[i].ma, tbl[i].mexp);
            if (tbl[i].wstart != 0) begin
                prog_we = 1'b1; prog_addr = AW'(tbl[i].maddr); prog_op = 3'(tbl[i].mop);
                prog_a = 4'(tbl[i].ma); prog_exp = 8'(tbl[i].mexp);
            end
            run_check($sformatf("row%0d", i), tbl[i].len, tbl[i].inj, tbl[i].e_err,
                      tbl[i].e_idx, tbl[i].e_seen, tbl[i].e_lat);
        end

        // Reset during the first SETUP cycle of step 1, then a clean rerun
        load_base();
        run_len = 5'd3; start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("setup1 alu_op", alu_op, 3'b001);
        check("setup1 alu_a", alu_a, 5);
        check("setup1 alu_load", alu_load, 0);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst alu_load", alu_load, 0);
        check("midrst done", done, 0);
        check("midrst alu_op", alu_op, 3'b111);
        check("midrst alu_keep", alu_keep, 1);
        run_check("rerun", 3, 0, 0, 0, 0, 14);

        // Full-depth run of hold steps
        for (int i = 0; i < DEPTH; i++) write_entry(i, 7, 0, 0);
        run_check("depth16", 16, 0, 0, 0, 0, 66);

        // Random programs against a step-by-step reference
        for (int t = 0; t < 20; t++) begin
            logic [7:0] acc;
            int len, e_err, e_idx, e_seen;
            acc = 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mop[i] = 3'($urandom_range(0, 7));
                ma[i]  = 4'($urandom);
                acc    = alu_f(mop[i], ma[i], acc);
                mexp[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : acc;
                write_entry(i, int'(mop[i]), int'(ma[i]), int'(mexp[i]));
            end
            len = $urandom_range(0, DEPTH);
            acc = 8'h00; e_err = 0; e_idx = 0; e_seen = 0;
            for (int i = 0; i < len; i++) begin
                acc = alu_f(mop[i], ma[i], acc);
                if (acc != mexp[i]) begin
                    if (e_seen == 0) begin e_idx = i; e_seen = 1; end
                    e_err++;
                end
            end
            run_check($sformatf("rand%0d", t), len, 0, e_err, e_idx, e_seen,
                      (len == 0) ? 1 : 2 + 4 * len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
